// File: rtl/sccb_pkg.sv
// rtl/sccb_pkg.sv - shared states and bus constants for the SCCB register target
package sccb_pkg;

    typedef enum logic [3:0] {
        IDLE,
        DEV,
        DEV_ACK,
        RAH,
        RAH_ACK,
        RAL,
        RAL_ACK,
        WDAT,
        WDAT_ACK,
        RDAT,
        RDAT_ACK,
        IGNORE
    } sccb_state_e;

    localparam logic ACK         = 1'b0;
    localparam logic NACK        = 1'b1;
    localparam int   SYNC_STAGES = 2;

endpackage

// File: rtl/sccb_target_regfile.sv
// rtl/sccb_target_regfile.sv - byte register file, synchronous write, combinational read
module sccb_target_regfile #(
    parameter int          REG_AW  = 8,
    parameter logic [7:0]  RST_VAL = 8'h00
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [REG_AW-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [2**REG_AW];

    // Every entry is cleared in the same reset cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < 2**REG_AW; i++) begin
                mem[i] <= RST_VAL;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sccb_target.sv
// rtl/sccb_target.sv - oversampled I2C/SCCB responder with 16-bit register addressing
module sccb_target
    import sccb_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h3C,
    parameter int         REG_AW   = 8,
    parameter logic [7:0] RST_VAL  = 8'h00
) (
    input  logic        CLK_SYS,
    input  logic        RESETn,
    input  logic        SCL,
    inout  wire         SDA,
    output logic        wr_strobe,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy,
    output logic        nack_err
);

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_s, sda_s, scl_h, sda_h;
    logic scl_rise, scl_fall, start_det, stop_det;

    sccb_state_e state, state_n;
    logic [2:0]  cnt, cnt_n;
    logic [7:0]  shreg, shreg_n, txd, txd_n, rx_byte;
    logic [15:0] reg_addr, reg_addr_n;
    logic        rw, rw_n, sda_oe, sda_oe_n, busy_n, nack_err_n;
    logic        mack, mack_n, ack_seen, ack_seen_n;
    logic        wr_strobe_n;
    logic [15:0] wr_addr_n;
    logic [7:0]  wr_data_n;
    logic [REG_AW-1:0] rd_index;
    logic [7:0]  rd_data;

    assign SDA = sda_oe ? 1'b0 : 1'bz;

    // Sync flops reset high so the idle bus does not look like an edge.
    always_ff @(posedge CLK_SYS) begin
        if (!RESETn) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_h    <= 1'b1;
            sda_h    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], SCL};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], SDA};
            scl_h    <= scl_s;
            sda_h    <= sda_s;
        end
    end

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_h;
    assign scl_fall  = ~scl_s & scl_h;
    assign start_det = scl_s & scl_h & sda_h & ~sda_s;
    assign stop_det  = scl_s & scl_h & ~sda_h & sda_s;

    // During a read ACK slot the next byte is prefetched from reg_addr+1.
    assign rd_index = (state == RDAT_ACK) ? reg_addr[REG_AW-1:0] + REG_AW'(1)
                                          : reg_addr[REG_AW-1:0];

    sccb_target_regfile #(
        .REG_AW  (REG_AW),
        .RST_VAL (RST_VAL)
    ) u_regfile (
        .clk    (CLK_SYS),
        .resetn (RESETn),
        .we     (wr_strobe),
        .waddr  (wr_addr[REG_AW-1:0]),
        .wdata  (wr_data),
        .raddr  (rd_index),
        .rdata  (rd_data)
    );

    always_ff @(posedge CLK_SYS) begin
        if (!RESETn) begin
            state     <= IDLE;
            cnt       <= '0;
            shreg     <= '0;
            txd       <= '0;
            reg_addr  <= '0;
            rw        <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            nack_err  <= 1'b0;
            mack      <= NACK;
            ack_seen  <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            shreg     <= shreg_n;
            txd       <= txd_n;
            reg_addr  <= reg_addr_n;
            rw        <= rw_n;
            sda_oe    <= sda_oe_n;
            busy      <= busy_n;
            nack_err  <= nack_err_n;
            mack      <= mack_n;
            ack_seen  <= ack_seen_n;
            wr_strobe <= wr_strobe_n;
            wr_addr   <= wr_addr_n;
            wr_data   <= wr_data_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        shreg_n     = shreg;
        txd_n       = txd;
        reg_addr_n  = reg_addr;
        rw_n        = rw;
        sda_oe_n    = sda_oe;
        busy_n      = busy;
        nack_err_n  = nack_err;
        mack_n      = mack;
        ack_seen_n  = ack_seen;
        wr_strobe_n = 1'b0;
        wr_addr_n   = wr_addr;
        wr_data_n   = wr_data;
        rx_byte     = {shreg[6:0], sda_s};

        if (start_det) begin
            state_n    = DEV;
            cnt_n      = '0;
            sda_oe_n   = 1'b0;
            busy_n     = 1'b1;
            ack_seen_n = 1'b0;
        end else if (stop_det) begin
            state_n    = IDLE;
            cnt_n      = '0;
            sda_oe_n   = 1'b0;
            busy_n     = 1'b0;
            ack_seen_n = 1'b0;
        end else begin
            case (state)
                DEV, RAH, RAL, WDAT: begin
                    if (scl_rise) begin
                        shreg_n = rx_byte;
                        cnt_n   = cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            case (state)
                                DEV: begin
                                    if (rx_byte[7:1] == DEV_ADDR) begin
                                        state_n = DEV_ACK;
                                        rw_n    = rx_byte[0];
                                    end else begin
                                        state_n    = IGNORE;
                                        nack_err_n = 1'b1;
                                    end
                                end
                                RAH: begin
                                    reg_addr_n[15:8] = rx_byte;
                                    state_n          = RAH_ACK;
                                end
                                RAL: begin
                                    reg_addr_n[7:0] = rx_byte;
                                    state_n         = RAL_ACK;
                                end
                                default: begin
                                    wr_strobe_n = 1'b1;
                                    wr_addr_n   = reg_addr;
                                    wr_data_n   = rx_byte;
                                    state_n     = WDAT_ACK;
                                end
                            endcase
                        end
                    end
                end
                // First SCL fall pulls SDA low for the ACK, the second releases it.
                DEV_ACK, RAH_ACK, RAL_ACK, WDAT_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe) begin
                            sda_oe_n = 1'b1;
                        end else begin
                            sda_oe_n = 1'b0;
                            cnt_n    = '0;
                            case (state)
                                DEV_ACK: begin
                                    if (rw) begin
                                        state_n  = RDAT;
                                        txd_n    = rd_data;
                                        sda_oe_n = ~rd_data[7];
                                    end else begin
                                        state_n = RAH;
                                    end
                                end
                                RAH_ACK: state_n = RAL;
                                RAL_ACK: state_n = WDAT;
                                default: begin
                                    state_n    = WDAT;
                                    reg_addr_n = reg_addr + 16'd1;
                                end
                            endcase
                        end
                    end
                end
                RDAT: begin
                    if (scl_rise) begin
                        cnt_n = cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            state_n    = RDAT_ACK;
                            ack_seen_n = 1'b0;
                        end
                    end else if (scl_fall) begin
                        txd_n    = {txd[6:0], 1'b0};
                        sda_oe_n = ~txd[6];
                    end
                end
                RDAT_ACK: begin
                    if (scl_rise) begin
                        mack_n     = sda_s;
                        ack_seen_n = 1'b1;
                    end else if (scl_fall) begin
                        if (!ack_seen) begin
                            sda_oe_n = 1'b0;
                        end else begin
                            ack_seen_n = 1'b0;
                            cnt_n      = '0;
                            if (mack == ACK) begin
                                reg_addr_n = reg_addr + 16'd1;
                                state_n    = RDAT;
                                txd_n      = rd_data;
                                sda_oe_n   = ~rd_data[7];
                            end else begin
                                state_n  = IGNORE;
                                sda_oe_n = 1'b0;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sccb_target.sv
// tb/tb_sccb_target.sv - directed bus-master bench with a transaction-level register model
module tb_sccb_target;

    localparam int Q = 8;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic m_scl = 1'b1;
    logic m_oe = 1'b0;
    wire  sda;
    logic        wr_strobe;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        nack_err;

    assign sda = m_oe ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    sccb_target dut (
        .CLK_SYS   (clk),
        .RESETn    (resetn),
        .SCL       (m_scl),
        .SDA       (sda),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy      (busy),
        .nack_err  (nack_err)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  mdl_mem [256];
    logic [15:0] mdl_addr;
    logic [23:0] exp_q [$];
    logic [23:0] exp_e;
    logic [15:0] last_wr_addr = '0;
    logic [15:0] prev_wr_addr = '0;
    int          strobe_cnt = 0;
    logic        prev_strobe = 1'b0;
    logic        watch_nodrive = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Write scoreboard and forbidden-drive watch, sampled 1 ns after the active edge.
    always begin
        @(posedge clk);
        #1;
        if (resetn) begin
            if (wr_strobe) begin
                strobe_cnt++;
                prev_wr_addr = last_wr_addr;
                last_wr_addr = wr_addr;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected actual=%h/%h required=none", wr_addr, wr_data);
                end else begin
                    exp_e = exp_q.pop_front();
                    if ({wr_addr, wr_data} !== exp_e) begin
                        errors++;
                        $display("FAIL wr_event actual=%h required=%h", {wr_addr, wr_data}, exp_e);
                    end
                end
                checks++;
                if (prev_strobe) begin
                    errors++;
                    $display("FAIL wr_pulse_width actual=2+ required=1");
                end
            end
            if (watch_nodrive && !m_oe) begin
                checks++;
                if (sda === 1'b0) begin
                    errors++;
                    $display("FAIL sda_driven actual=0 required=released");
                end
            end
        end
        prev_strobe = wr_strobe;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        m_oe = 1'b0; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_oe = 1'b1; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic bus_stop();
        m_oe = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_oe = 1'b0; tick(Q);
    endtask

    task automatic bus_bit(input logic drive_low, output logic seen);
        m_oe = drive_low; tick(Q);
        m_scl = 1'b1; tick(Q);
        seen = sda;
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(~b[i], s);
        bus_bit(1'b0, s);
        acked = (s === 1'b0);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b0, s);
            d[i] = s;
        end
        bus_bit(~nack, s);
    endtask

    // Model: a target acknowledges only its own 7-bit address; all other bytes in
    // an addressed transfer are acknowledged.
    task automatic send_dev(input logic [7:0] b, input string name);
        logic a;
        write_byte(b, a);
        check(name, a, (b[7:1] == 7'h3C));
    endtask

    task automatic txn_addr(input logic [15:0] addr);
        logic a;
        bus_start();
        send_dev(8'h78, "dev_w_ack");
        write_byte(addr[15:8], a); check("rah_ack", a, 1'b1);
        write_byte(addr[7:0], a);  check("ral_ack", a, 1'b1);
        mdl_addr = addr;
    endtask

    task automatic txn_wdata(input logic [7:0] b);
        logic a;
        exp_q.push_back({mdl_addr, b});
        mdl_mem[mdl_addr[7:0]] = b;
        write_byte(b, a);
        check("wdat_ack", a, 1'b1);
        mdl_addr = mdl_addr + 16'd1;
    endtask

    task automatic txn_rd_start();
        bus_start();
        send_dev(8'h79, "dev_r_ack");
    endtask

    task automatic txn_rdata(input logic nack, output logic [7:0] d);
        read_byte(nack, d);
        check("rdat_model", d, mdl_mem[mdl_addr[7:0]]);
        if (!nack) mdl_addr = mdl_addr + 16'd1;
    endtask

    initial begin
        logic [7:0] d;
        logic       a, s;
        int         sc;

        for (int i = 0; i < 256; i++) mdl_mem[i] = 8'h00;
        mdl_addr = '0;
        tick(4);
        resetn = 1'b1;
        tick(2);
        check("rst_busy", busy, 1'b0);
        check("rst_nack_err", nack_err, 1'b0);
        check("rst_wr_strobe", wr_strobe, 1'b0);
        check("rst_wr_addr", wr_addr, 16'h0000);
        check("rst_sda", sda, 1'b1);

        // Plain write 0x42 to 0x3008
        txn_addr(16'h3008);
        txn_wdata(8'h42);
        check("busy_in_txn", busy, 1'b1);
        bus_stop();
        tick(6);
        check("busy_after_stop", busy, 1'b0);
        check("write_addr_lit", last_wr_addr, 16'h3008);
        check("write_count", strobe_cnt, 1);

        // Random read of 0x3008
        txn_addr(16'h3008);
        txn_rd_start();
        txn_rdata(1'b1, d);
        check("rand_read_lit", d, 8'h42);
        watch_nodrive = 1'b1;
        bus_stop();
        tick(4);
        watch_nodrive = 1'b0;
        check("rand_read_nack_err", nack_err, 1'b0);
        check("rand_read_no_write", strobe_cnt, 1);

        // Burst write across the 16-bit wrap, then read it back
        txn_addr(16'hFFFF);
        txn_wdata(8'hA1);
        txn_wdata(8'hA2);
        bus_stop();
        tick(4);
        check("wrap_addr0", prev_wr_addr, 16'hFFFF);
        check("wrap_addr1", last_wr_addr, 16'h0000);
        txn_addr(16'hFFFF);
        txn_rd_start();
        txn_rdata(1'b0, d);
        check("wrap_rd0_lit", d, 8'hA1);
        txn_rdata(1'b1, d);
        check("wrap_rd1_lit", d, 8'hA2);
        bus_stop();
        tick(4);

        // Foreign address: target stays silent and flags the mismatch
        sc = strobe_cnt;
        watch_nodrive = 1'b1;
        bus_start();
        send_dev(8'h50, "bad_dev_nack");
        write_byte(8'h12, a); check("bad_b1_nack", a, 1'b0);
        write_byte(8'h34, a); check("bad_b2_nack", a, 1'b0);
        write_byte(8'h56, a); check("bad_b3_nack", a, 1'b0);
        bus_stop();
        tick(4);
        watch_nodrive = 1'b0;
        check("bad_nack_err", nack_err, 1'b1);
        check("bad_no_write", strobe_cnt, sc);
        check("bad_busy", busy, 1'b0);
        txn_addr(16'h0010);
        txn_wdata(8'h55);
        bus_stop();
        tick(4);
        check("after_bad_write", last_wr_addr, 16'h0010);
        check("nack_err_sticky", nack_err, 1'b1);

        // Abort after half a data byte
        sc = strobe_cnt;
        txn_addr(16'h0020);
        for (int i = 0; i < 4; i++) bus_bit(1'b0, s);
        bus_stop();
        tick(6);
        check("abort_no_write", strobe_cnt, sc);
        check("abort_idle", busy, 1'b0);
        bus_start();
        send_dev(8'h78, "abort_next_ack");
        bus_stop();
        tick(4);

        // Reset while the target drives the MSB (0) of 0x55
        txn_addr(16'h0010);
        txn_rd_start();
        check("rd_driving", sda, 1'b0);
        resetn = 1'b0;
        tick(1);
        check("rst_mid_sda", sda, 1'b1);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_nack_err", nack_err, 1'b0);
        resetn = 1'b1;
        for (int i = 0; i < 256; i++) mdl_mem[i] = 8'h00;
        mdl_addr = '0;
        tick(2);
        bus_stop();
        tick(4);
        txn_addr(16'h0010);
        txn_rd_start();
        txn_rdata(1'b1, d);
        check("rst_regfile_lit", d, 8'h00);
        bus_stop();
        tick(6);

        check("pending_writes", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sccb_target.md
Name: sccb_target

Overview:
- I2C/SCCB responder: the far end of the camera initialisation master. It models the camera's register port for system-level simulation and serves as an on-chip debug target.
- Decodes START/STOP, a 7-bit device address, a 16-bit register address (MSB byte first) and data bytes.
- Writes go into an internal register file; reads return register contents. The register address auto-increments after every data byte.
- SCL and SDA are oversampled on CLK_SYS. SDA is open-drain: driven 0 or released to Z.

Parameters:
DEV_ADDR, 7'h3C, 7-bit device address this target acknowledges
REG_AW, 8, register file index width; depth 2^REG_AW; index = reg_addr[REG_AW-1:0]
RST_VAL, 8'h00, reset content of every register file entry

Ports:
CLK_SYS  in  1  system clock
RESETn  in  1  synchronous active-low reset
SCL  in  1  I2C clock from master (asynchronous)
SDA  inout  1  I2C data; target drives 1'b0 or 1'bz only
wr_strobe  out  1  one-cycle pulse per accepted write data byte
wr_addr  out  16  register address of that write
wr_data  out  8  data byte of that write
busy  out  1  high from a START until the following STOP
nack_err  out  1  sticky; set when an address byte does not match; cleared by reset only

Behaviour:
- Reset (RESETn=0 at a CLK_SYS edge): FSM to IDLE; SDA released (Z); every output 0; reg_addr=0; register file entries to RST_VAL (loaded over 2^REG_AW cycles is not allowed; reset is single-cycle).
- Input sync: SCL and SDA each pass through 2 flops plus a history flop. Edges are detected on the synchronised values, so latency is 3 CLK_SYS cycles.
- Bus event detection:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Both take priority over any FSM state, including repeated START mid-byte.
- Sampling and driving:
  - Data is sampled on the synchronised SCL rising edge, MSB first, with a 3-bit bit counter.
  - SDA is changed one CLK_SYS after the synchronised SCL falling edge.
- FSM states: IDLE, DEV, DEV_ACK, RAH, RAH_ACK, RAL, RAL_ACK, WDAT, WDAT_ACK, RDAT, RDAT_ACK, IGNORE.
  - IDLE -> DEV on START; busy=1.
  - DEV: shift 8 bits. If byte[7:1]==DEV_ADDR, go to DEV_ACK and remember R/W=byte[0]. Otherwise go to IGNORE and set nack_err.
  - DEV_ACK: drive SDA=0 for one SCL period. Then go to RDAT if R/W=1, or to RAH if R/W=0.
  - RAH -> RAH_ACK: load reg_addr[15:8], ACK.
  - RAL -> RAL_ACK: load reg_addr[7:0], ACK, then go to WDAT.
  - WDAT: on the 8th bit, go to WDAT_ACK. wr_strobe=1 for one cycle with wr_addr=reg_addr, and the entry is written. Then ACK and reg_addr+=1.
  - RDAT: shift out the entry at the current reg_addr, MSB first. The byte is latched at the SCL fall that enters RDAT. Then release SDA in RDAT_ACK and sample the master's bit:
    - ACK(0): reg_addr+=1, then RDAT.
    - NACK(1): IGNORE.
  - IGNORE: SDA released until START or STOP.
  - Any state -> IDLE on STOP: busy=0, SDA released.
  - Any state -> DEV on START: bit counter cleared, SDA released.
- reg_addr arithmetic: 16-bit, wraps 16'hFFFF -> 16'h0000. The index uses the low REG_AW bits, so the register file aliases.
- A write to RAH/RAL followed by a repeated START with R/W=1 reads from the newly set address. This is the SCCB random read.
- A read with no preceding address phase uses the retained reg_addr.
- SDA is never driven while SCL is high, except to hold an ACK or data bit stable.

Decomposition:
- Package sccb_pkg holds:
  - FSM state enum.
  - Constants: ACK=1'b0, NACK=1'b1, SYNC_STAGES=2.
- One sub-module, sccb_target_regfile: 2^REG_AW x 8, synchronous write, combinational read, reset to RST_VAL.

Test Plan:
- Write: START, 0x78, 0x30, 0x08, 0x42, STOP -> 4 ACKs; wr_strobe once with wr_addr=0x3008, wr_data=0x42; busy returns to 0 after STOP.
- Random read:
  - START, 0x78, 0x30, 0x08.
  - Repeated START, 0x79; master NACK; STOP.
  - Expected: 0x42 is shifted out; SDA is released after the NACK; nack_err=0.
- Burst with wrap:
  - Set address 0xFFFF, then write 0xA1, 0xA2.
  - Expected: wr_addr sequence 0xFFFF, 0x0000.
  - Read back from 0xFFFF with 2 bytes, ACK then NACK: returns 0xA1, 0xA2.
- Wrong address:
  - START, 0x50, then 3 bytes, then STOP.
  - Expected: SDA is never driven, no wr_strobe, nack_err=1.
  - A subsequent valid transfer succeeds.
- Abort: STOP after 4 bits of the data byte -> no wr_strobe; FSM IDLE; next START, 0x78 is ACKed.
- Reset mid-read: assert RESETn=0 while RDAT is driving SDA=0 -> SDA Z the next cycle; busy=0; register file reads RST_VAL.
